// File: rtl/snake_pkg.sv
// Shared encodings and geometry for the snake game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int GRID  = 5;
    localparam int X_MAX = 640;
    localparam int Y_MAX = 480;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [9:0] APPLE_X_RST = 10'd400;
    localparam logic [8:0] APPLE_Y_RST = 9'd200;

    // Cell index to pixel origin: GRID + 5*c, with the multiply done as shift-add
    function automatic logic [9:0] cellToPix(input logic [6:0] c);
        logic [9:0] w;
        w = {3'd0, c};
        return (w << 2) + w + 10'(GRID);
    endfunction

endpackage

// File: rtl/apple_gen.sv
// Apple placement: free-running LFSR, relocation arithmetic and registered apple pixel flag.
module apple_gen
    import snake_pkg::*;
(
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       relocate,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic [9:0] appleX,
    output logic [8:0] appleY,
    output logic       apple
);

    logic [15:0] lfsr_r;
    logic [9:0]  appleX_r;
    logic [8:0]  appleY_r;
    logic        apple_r;
    logic        feedback_s;
    logic [6:0]  cx_s;
    logic [6:0]  cy_s;
    logic [9:0]  newX_s;
    logic [8:0]  newY_s;
    logic        appleHit_s;

    // Feedback, folded cell coordinates and the pixel-inside-apple test
    always_comb begin
        feedback_s = ^(lfsr_r & LFSR_TAPS);
        cx_s       = (lfsr_r[6:0] > 7'd125) ? (lfsr_r[6:0] - 7'd64) : lfsr_r[6:0];
        cy_s       = (lfsr_r[14:8] > 7'd93) ? (lfsr_r[14:8] - 7'd64) : lfsr_r[14:8];
        newX_s     = cellToPix(cx_s);
        newY_s     = 9'(cellToPix(cy_s));
        appleHit_s = (xCount > appleX_r) && (xCount < (appleX_r + 10'(GRID))) &&
                     (yCount > {1'b0, appleY_r}) && (yCount < ({1'b0, appleY_r} + 10'(GRID)));
    end

    // LFSR advance, apple position update and flag register
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            lfsr_r   <= LFSR_SEED;
            appleX_r <= APPLE_X_RST;
            appleY_r <= APPLE_Y_RST;
            apple_r  <= 1'b0;
        end else begin
            lfsr_r  <= {lfsr_r[14:0], feedback_s};
            apple_r <= appleHit_s;
            if (relocate) begin
                appleX_r <= newX_s;
                appleY_r <= newY_s;
            end else begin
                appleX_r <= appleX_r;
                appleY_r <= appleY_r;
            end
        end
    end

    assign appleX = appleX_r;
    assign appleY = appleY_r;
    assign apple  = apple_r;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move strobes, length/score bookkeeping and collision detection per frame.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MOVE_FRAMES = 4,
    parameter int INIT_SIZE   = 3,
    parameter int MAX_SIZE    = 31
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       frame_end,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    input  logic       snakeHead,
    input  logic       snakeBody,
    output logic       update,
    output logic       start,
    output logic [4:0] size,
    output logic       apple,
    output logic [9:0] appleX,
    output logic [8:0] appleY,
    output logic       game_over,
    output logic [7:0] score
);

    localparam logic [3:0] LAST_FRAME = 4'(MOVE_FRAMES - 1);

    state_t     state_r, state_n;
    logic       prevBtn_r, btnRise_s;
    logic [9:0] xReg_r, yReg_r;
    logic       border_s;
    logic       hitSelf_r, hitSelf_n, hitWall_r, hitWall_n, ate_r, ate_n;
    logic [3:0] counter_r, counter_n;
    logic       update_r, update_n, start_r, gameOver_r;
    logic [4:0] size_r, size_n;
    logic [7:0] score_r, score_n;
    logic       relocate_s;

    apple_gen u_apple (
        .VGA_clk (VGA_clk),
        .reset   (reset),
        .relocate(relocate_s),
        .xCount  (xCount),
        .yCount  (yCount),
        .appleX  (appleX),
        .appleY  (appleY),
        .apple   (apple)
    );

    // Next-state, sticky collision flags and frame-end bookkeeping
    always_comb begin
        state_n    = state_r;
        update_n   = 1'b0;
        size_n     = size_r;
        score_n    = score_r;
        counter_n  = counter_r;
        relocate_s = 1'b0;
        btnRise_s  = start_btn & ~prevBtn_r;
        border_s   = (xReg_r < 10'(GRID)) || (xReg_r >= 10'(X_MAX - GRID)) ||
                     (yReg_r < 10'(GRID)) || (yReg_r >= 10'(Y_MAX - GRID));

        // Flags are consumed on frame_end, so clearing there loses nothing
        if (frame_end) begin
            hitSelf_n = 1'b0;
            hitWall_n = 1'b0;
            ate_n     = 1'b0;
        end else if (state_r == PLAY) begin
            hitSelf_n = hitSelf_r | (snakeHead & snakeBody);
            hitWall_n = hitWall_r | (snakeHead & border_s);
            ate_n     = ate_r     | (snakeHead & apple);
        end else begin
            hitSelf_n = hitSelf_r;
            hitWall_n = hitWall_r;
            ate_n     = ate_r;
        end

        case (state_r)
            IDLE: begin
                size_n = 5'(INIT_SIZE);
                if (btnRise_s) begin
                    state_n   = PLAY;
                    score_n   = 8'd0;
                    counter_n = 4'd0;
                end else begin
                    update_n = frame_end;
                end
            end
            PLAY: begin
                if (frame_end) begin
                    if (hitSelf_r | hitWall_r) begin
                        state_n = DEAD;
                    end else begin
                        if (ate_r) begin
                            size_n     = (size_r < 5'(MAX_SIZE)) ? (size_r + 5'd1) : size_r;
                            score_n    = (score_r != 8'd255) ? (score_r + 8'd1) : score_r;
                            relocate_s = 1'b1;
                        end else begin
                            relocate_s = 1'b0;
                        end
                        if (counter_r == LAST_FRAME) begin
                            update_n  = 1'b1;
                            counter_n = 4'd0;
                        end else begin
                            counter_n = counter_r + 4'd1;
                        end
                    end
                end else begin
                    state_n = PLAY;
                end
            end
            DEAD: begin
                if (btnRise_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DEAD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_r    <= IDLE;
            prevBtn_r  <= 1'b0;
            xReg_r     <= 10'd0;
            yReg_r     <= 10'd0;
            hitSelf_r  <= 1'b0;
            hitWall_r  <= 1'b0;
            ate_r      <= 1'b0;
            counter_r  <= 4'd0;
            update_r   <= 1'b0;
            start_r    <= 1'b0;
            gameOver_r <= 1'b0;
            size_r     <= 5'(INIT_SIZE);
            score_r    <= 8'd0;
        end else begin
            state_r    <= state_n;
            prevBtn_r  <= start_btn;
            xReg_r     <= xCount;
            yReg_r     <= yCount;
            hitSelf_r  <= hitSelf_n;
            hitWall_r  <= hitWall_n;
            ate_r      <= ate_n;
            counter_r  <= counter_n;
            update_r   <= update_n;
            start_r    <= (state_n != IDLE);
            gameOver_r <= (state_n == DEAD);
            size_r     <= size_n;
            score_r    <= score_n;
        end
    end

    assign update    = update_r;
    assign start     = start_r;
    assign game_over = gameOver_r;
    assign size      = size_r;
    assign score     = score_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl with an independent apple LFSR model.
module tb_snake_game_ctrl;

    logic       VGA_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0;
    logic       frame_end = 1'b0;
    logic [9:0] xCount = 10'd300;
    logic [9:0] yCount = 10'd300;
    logic       snakeHead = 1'b0;
    logic       snakeBody = 1'b0;
    logic       update, start, apple, game_over;
    logic [4:0] size;
    logic [9:0] appleX;
    logic [8:0] appleY;
    logic [7:0] score;

    int checkCount = 0;
    int failCount  = 0;

    logic [15:0] mLfsr = 16'hACE1;
    logic [15:0] lfsrAtFe = 16'h0000;
    logic        u;
    logic [9:0]  ax;
    logic [8:0]  ay;

    snake_game_ctrl dut (
        .VGA_clk  (VGA_clk),
        .reset    (reset),
        .start_btn(start_btn),
        .frame_end(frame_end),
        .xCount   (xCount),
        .yCount   (yCount),
        .snakeHead(snakeHead),
        .snakeBody(snakeBody),
        .update   (update),
        .start    (start),
        .size     (size),
        .apple    (apple),
        .appleX   (appleX),
        .appleY   (appleY),
        .game_over(game_over),
        .score    (score)
    );

    always #5 VGA_clk = ~VGA_clk;

    // Reference LFSR; remembers its value at each frame_end edge
    always @(posedge VGA_clk) begin
        if (frame_end) lfsrAtFe <= mLfsr;
        if (reset) mLfsr <= 16'hACE1;
        else       mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    end

    function automatic logic [9:0] expX(input logic [15:0] l);
        int c;
        c = int'(l[6:0]);
        if (c > 125) c = c - 64;
        return 10'(5 + 5 * c);
    endfunction

    function automatic logic [8:0] expY(input logic [15:0] l);
        int c;
        c = int'(l[14:8]);
        if (c > 93) c = c - 64;
        return 9'(5 + 5 * c);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic head, input logic body);
        @(negedge VGA_clk);
        xCount = x;
        yCount = y;
        @(negedge VGA_clk);
        xCount    = 10'd300;
        yCount    = 10'd300;
        snakeHead = head;
        snakeBody = body;
        @(negedge VGA_clk);
        snakeHead = 1'b0;
        snakeBody = 1'b0;
    endtask

    task automatic endFrame(output logic upd);
        @(negedge VGA_clk);
        frame_end = 1'b1;
        @(negedge VGA_clk);
        frame_end = 1'b0;
        upd = update;
    endtask

    task automatic pressBtn();
        @(negedge VGA_clk);
        start_btn = 1'b1;
        @(negedge VGA_clk);
        start_btn = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge VGA_clk);
        reset = 1'b0;
        @(negedge VGA_clk);
        checkVal("rst_update", update, 0);
        checkVal("rst_start", start, 0);
        checkVal("rst_size", size, 3);
        checkVal("rst_score", score, 0);
        checkVal("rst_gameover", game_over, 0);
        checkVal("rst_apple", apple, 0);
        checkVal("rst_appleX", appleX, 400);
        checkVal("rst_appleY", appleY, 200);

        for (int i = 0; i < 3; i++) begin
            endFrame(u);
            checkVal("idle_update", u, 1);
            @(negedge VGA_clk);
            checkVal("idle_update_drop", update, 0);
        end
        checkVal("idle_start", start, 0);
        checkVal("idle_size", size, 3);
        checkVal("idle_appleX", appleX, 400);
        checkVal("idle_appleY", appleY, 200);

        pressBtn();
        checkVal("play_start", start, 1);
        checkVal("play_gameover", game_over, 0);
        for (int f = 1; f <= 8; f++) begin
            endFrame(u);
            checkVal("move_update", u, (f % 4 == 0) ? 1 : 0);
        end

        pixel(10'd402, 10'd202, 1'b1, 1'b0);
        endFrame(u);
        checkVal("eat_update", u, 0);
        checkVal("eat_size", size, 4);
        checkVal("eat_score", score, 1);
        ax = expX(lfsrAtFe);
        ay = expY(lfsrAtFe);
        checkVal("eat_appleX", appleX, ax);
        checkVal("eat_appleY", appleY, ay);
        checkVal("eat_x_range", (appleX % 5 == 0) && (appleX >= 5) && (appleX <= 630), 1);
        checkVal("eat_y_range", (appleY % 5 == 0) && (appleY >= 5) && (appleY <= 470), 1);

        pixel(10'd2, 10'd300, 1'b1, 1'b0);
        endFrame(u);
        checkVal("wall_update", u, 0);
        checkVal("wall_gameover", game_over, 1);
        checkVal("wall_start", start, 1);
        for (int i = 0; i < 2; i++) begin
            endFrame(u);
            checkVal("dead_update", u, 0);
        end
        checkVal("dead_size", size, 4);
        checkVal("dead_score", score, 1);

        pressBtn();
        @(negedge VGA_clk);
        checkVal("back_idle_start", start, 0);
        checkVal("back_idle_gameover", game_over, 0);
        checkVal("back_idle_size", size, 3);

        @(negedge VGA_clk);
        start_btn = 1'b1;
        frame_end = 1'b1;
        @(negedge VGA_clk);
        start_btn = 1'b0;
        frame_end = 1'b0;
        checkVal("coinc_update", update, 0);
        checkVal("coinc_start", start, 1);
        checkVal("coinc_score", score, 0);

        pixel(ax + 10'd2, 10'({1'b0, ay}) + 10'd2, 1'b1, 1'b1);
        endFrame(u);
        checkVal("self_update", u, 0);
        checkVal("self_gameover", game_over, 1);
        checkVal("self_size", size, 3);
        checkVal("self_score", score, 0);
        checkVal("self_appleX", appleX, ax);

        pressBtn();
        @(negedge VGA_clk);
        pressBtn();
        checkVal("replay_start", start, 1);
        for (int k = 0; k < 28; k++) begin
            pixel(appleX + 10'd2, 10'({1'b0, appleY}) + 10'd2, 1'b1, 1'b0);
            endFrame(u);
            checkVal("reloc_x", appleX, expX(lfsrAtFe));
        end
        checkVal("grow_size", size, 31);
        checkVal("grow_score", score, 28);
        pixel(appleX + 10'd2, 10'({1'b0, appleY}) + 10'd2, 1'b1, 1'b0);
        endFrame(u);
        checkVal("sat_size", size, 31);
        checkVal("sat_score", score, 29);
        checkVal("sat_gameover", game_over, 0);

        @(negedge VGA_clk);
        reset = 1'b1;
        @(negedge VGA_clk);
        checkVal("mid_rst_start", start, 0);
        checkVal("mid_rst_size", size, 3);
        checkVal("mid_rst_score", score, 0);
        checkVal("mid_rst_appleX", appleX, 400);
        reset = 1'b0;
        @(negedge VGA_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the snake datapath. It generates the snake_body `update` move strobe and the `start` level, and owns the length (`size`) and the score. It also places the apple and detects wall, self and apple collisions from per-pixel flags during each VGA frame. It sits between the VGA timing generator, the start button and snake_body, in the VGA_clk domain.

Parameters:
MOVE_FRAMES, 4, frames between move strobes in PLAY (range 1..15)
INIT_SIZE, 3, snake length loaded on entering PLAY
MAX_SIZE, 31, saturation limit for size
GRID, 5, cell size in pixels
X_MAX, 640, visible width
Y_MAX, 480, visible height
LFSR_SEED, 16'hACE1, apple LFSR reset value

Ports:
VGA_clk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
start_btn  in  1  debounced start button level; rising edge used
frame_end  in  1  one-cycle pulse after the last visible pixel of each frame
xCount  in  10  current pixel x
yCount  in  10  current pixel y
snakeHead  in  1  head pixel flag from snake_body (registered one cycle after xCount/yCount)
snakeBody  in  1  body pixel flag from snake_body (same alignment)
update  out  1  one-cycle move strobe to snake_body
start  out  1  play-enable level to snake_body
size  out  5  current snake length
apple  out  1  apple pixel flag
appleX  out  10  apple cell origin x
appleY  out  9  apple cell origin y
game_over  out  1  high in DEAD
score  out  8  apples eaten, saturating at 255

Behaviour:
- Reset values: state=IDLE, update=0, start=0, size=INIT_SIZE, score=0, game_over=0, apple=0, appleX=400, appleY=200, lfsr=LFSR_SEED, frame counter=0, hit flags cleared.
- start_btn edge detect: register the previous level; btn_rise = start_btn & ~prev.
- Pipeline alignment: xCount/yCount are registered once. Border and apple flags are computed from the registered copies, so they align with snakeHead/snakeBody. The apple output is registered (1-cycle latency, same as the head flag).
- Border region: x<GRID or x>=X_MAX-GRID or y<GRID or y>=Y_MAX-GRID.
- Apple flag: x>appleX && x<appleX+GRID && y>appleY && y<appleY+GRID.
- Sticky per-frame flags, set only in PLAY and cleared on each frame_end after evaluation:
  - hit_self = snakeHead&snakeBody
  - hit_wall = snakeHead&border
  - ate = snakeHead&apple_pix
- IDLE:
  - start=0, game_over=0, size=INIT_SIZE.
  - update pulses on every frame_end, so snake_body reinitialises.
  - btn_rise → PLAY: score=0, frame counter=0, update held 0 that cycle.
- PLAY:
  - start=1.
  - On frame_end: if hit_self|hit_wall → DEAD, no update that frame.
  - Otherwise, if ate: size=min(size+1,MAX_SIZE), score=sat(score+1), and relocate the apple.
  - Otherwise, if counter==MOVE_FRAMES-1: update=1 and counter=0; else counter+1.
  - Death takes priority over eat. Eat and move may occur on the same frame_end.
  - btn_rise is ignored in PLAY.
- DEAD:
  - start stays 1, so the snake stays frozen and visible; no update pulses; game_over=1.
  - btn_rise → IDLE.
- update is never high for two consecutive cycles and only fires on a frame_end cycle.
- frame_end coincident with btn_rise in IDLE: the transition wins and no update is issued.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in all states.
- Apple relocation:
  - cx=lfsr[6:0], minus 64 if >125.
  - cy=lfsr[14:8], minus 64 if >93.
  - appleX=GRID+GRID*cx (max 630), appleY=GRID+GRID*cy (max 470).
  - Multiply by 5 is implemented as shift-add.
- Reset mid-operation: the next cycle is in reset state regardless of the current state or flags.

Decomposition:
- Package snake_pkg holds:
  - the state encoding IDLE=2'd0, PLAY=2'd1, DEAD=2'd2;
  - GRID, X_MAX, Y_MAX, LFSR_SEED and the LFSR tap mask;
  - the apple reset coordinates.
- One sub-module, apple_gen, contains the LFSR, the relocation arithmetic, the appleX/appleY registers and the registered apple pixel flag. It has a `relocate` strobe input.

Test Plan:
- Reset, then 3 frame_end pulses → update pulses 3 times, start=0, size=3, appleX=400/appleY=200.
- btn_rise, then 8 frames with no flags, MOVE_FRAMES=4 → start=1; update on the 4th and 8th frame_end only.
- Head and apple flags overlap at (402,202) in one frame → at frame_end size=4, score=1; new appleX/appleY are multiples of 5 within 5..630 / 5..470.
- snakeHead high at x=2 (border) → at frame_end state=DEAD, game_over=1, no update; later frame_ends give no update.
- In the same frame, snakeHead&snakeBody plus head on apple → DEAD; size and score unchanged.
- Force size=31 and eat → size stays 31, score increments. reset asserted mid-PLAY → next cycle start=0, size=3, score=0.
